// File: rtl/imem_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words and writes them to
// the instruction memory, holding the CPU until done. Define IMEM_LOADER_CHKSUM_EN for a trailing XOR checksum.
`timescale 1ns/1ps
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        wr_en_imem_o,
  output logic [31:0] wr_addr_imem_o,
  output logic [31:0] wr_instr_imem_o,
  output logic [15:0] words_loaded_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  state_dbg_o
);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_WORD   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
`ifdef IMEM_LOADER_CHKSUM_EN
    S_ERR    = 3'd5,
    S_CHK    = 3'd6
`else
    S_ERR    = 3'd5
`endif
  } state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);
`ifdef IMEM_LOADER_CHKSUM_EN
  localparam state_t S_FINISH = S_CHK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] words_q, words_d;
  logic        xfer;
  logic [15:0] hdr_count;

  // A byte moves when byte_valid_i and byte_ready_o are both high at a rising edge;
  // ready is registered so it stays low through reset and rises one cycle later.
  assign xfer      = byte_valid_i & ready_q;
  assign hdr_count = {count_q[15:8], byte_data_i};

`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0] xor_q, xor_d;
  always_comb begin
    xor_d = xor_q;
    if (xfer) xor_d = xor_q ^ byte_data_i;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) xor_q <= 8'h00;
    else        xor_q <= xor_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    words_d = words_q;
    case (state_q)
      S_HDR_HI: if (xfer) begin
        count_d[15:8] = byte_data_i;
        state_d       = S_HDR_LO;
      end
      S_HDR_LO: if (xfer) begin
        count_d = hdr_count;
        idx_d   = 2'd0;
        if (hdr_count == 16'd0)       state_d = S_FINISH;
        else if (hdr_count > MAX_W)   state_d = S_ERR;
        else                          state_d = S_WORD;
      end
      S_WORD: if (xfer) begin
        asm_d = {asm_q[23:0], byte_data_i};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        words_d = words_q + 16'd1;
        addr_d  = addr_q + 32'd4;
        state_d = (words_q + 16'd1 == count_q) ? S_FINISH : S_WORD;
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      S_CHK: if (xfer) state_d = ((xor_q ^ byte_data_i) == 8'h00) ? S_DONE : S_ERR;
`endif
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_HDR_HI;
    endcase
    ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) || (state_d == S_WORD);
`ifdef IMEM_LOADER_CHKSUM_EN
    if (state_d == S_CHK) ready_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_HDR_HI;
      ready_q <= 1'b0;
      count_q <= 16'd0;
      idx_q   <= 2'd0;
      asm_q   <= 32'd0;
      addr_q  <= BASE_ADDR;
      words_q <= 16'd0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      words_q <= words_d;
    end
  end

  // Strobe and status decode straight from state so reset clears them asynchronously.
  assign byte_ready_o    = ready_q;
  assign wr_en_imem_o    = (state_q == S_WRITE);
  assign wr_addr_imem_o  = addr_q;
  assign wr_instr_imem_o = asm_q;
  assign words_loaded_o  = words_q;
  assign done_o          = (state_q == S_DONE);
  assign err_o           = (state_q == S_ERR);
  assign cpu_hold_o      = (state_q != S_DONE);
  assign state_dbg_o     = state_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory write port (write-enable, write-instruction and address).
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instructions and writes them to consecutive word addresses.
- Holds the pipeline in reset via `cpu_hold_o` until the image is fully loaded.
- Sits beside `top`, between the host byte link (UART receiver or testbench) and the instruction memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be word-aligned.
- MAX_WORDS, 1024, largest word count accepted in the header; range 1..65535.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- byte_valid_i  in  1  host byte valid.
- byte_data_i  in  8  host byte.
- byte_ready_o  out  1  loader can accept a byte; transfer happens when valid and ready are both high at a rising edge.
- wr_en_imem_o  out  1  one-cycle instruction memory write strobe.
- wr_addr_imem_o  out  32  word-aligned byte address of the write.
- wr_instr_imem_o  out  32  instruction word to write.
- words_loaded_o  out  16  count of words written so far.
- cpu_hold_o  out  1  high keeps the pipeline in reset.
- done_o  out  1  image loaded successfully; sticky.
- err_o  out  1  load failed; sticky.

Behaviour:
- Reset values (while reset is low, applied asynchronously):
  - state = HDR_HI; byte_ready_o = 0; wr_en_imem_o = 0; wr_addr_imem_o = BASE_ADDR; wr_instr_imem_o = 0.
  - words_loaded_o = 0; cpu_hold_o = 1; done_o = 0; err_o = 0.
  - byte_ready_o rises in the first cycle after reset deasserts.
- Stream format: count_hi, count_lo (16-bit word count N, big-endian), then N words of 4 bytes each, MSB first. With CHKSUM enabled, one trailing checksum byte follows.
- States:
  - HDR_HI: ready=1; on transfer, latch count[15:8] and go to HDR_LO.
  - HDR_LO: ready=1; on transfer, latch count[7:0], then:
    - N==0 → DONE (or CHK when enabled).
    - N>MAX_WORDS → ERR.
    - otherwise → WORD, with byte index 0.
  - WORD: ready=1; each transfer shifts the byte into the assembly register (first byte lands in [31:24]). On the 4th byte → WRITE.
  - WRITE: ready=0 for exactly one cycle.
    - wr_en_imem_o=1, wr_instr_imem_o = assembled word, wr_addr_imem_o = BASE_ADDR + 4*words_loaded.
    - words_loaded_o increments on the same edge that ends the pulse.
    - If words_loaded reaches N → DONE (or CHK); else → WORD.
  - DONE: ready=0; done_o=1; cpu_hold_o falls on entry. Leaving DONE requires reset.
  - ERR: ready=0; err_o=1; cpu_hold_o stays 1. Leaving ERR requires reset.
- Latency: the write strobe is asserted in the cycle after the edge that accepts the 4th byte. Peak rate is 4 bytes per 5 cycles.
- Validity and ordering:
  - Bytes presented while ready=0 are not consumed; the host must hold them.
  - wr_addr_imem_o and wr_instr_imem_o are meaningful only while wr_en_imem_o=1.
  - done_o and err_o are never both 1.
- Address arithmetic: 32-bit, wraps modulo 2^32 with no error. words_loaded_o never exceeds N.
- Reset mid-load:
  - All state clears immediately, and any in-flight write strobe drops asynchronously.
  - The stream must restart from the header. Memory contents already written are not cleared.

Optional Feature:
- Macro: IMEM_LOADER_CHKSUM_EN.
- When defined:
  - Adds state CHK (ready=1), entered in place of DONE.
  - A running XOR accumulates over every byte, header included; it resets to 0.
  - On the checksum byte: if accumulated XOR ^ byte == 0 → DONE, else → ERR.
- When undefined: no CHK state and no accumulator; the stream ends after the last word.

Test Plan:
- After reset release, send 00 02 / 24 08 00 05 / 01 09 50 20 (BASE_ADDR=0) → two single-cycle strobes:
  - addr 0x0 with 0x24080005; addr 0x4 with 0x01095020.
  - words_loaded_o=2, done_o=1, cpu_hold_o=0.
- Header 00 00 → DONE with no write strobe; cpu_hold_o falls 1 cycle after count_lo is accepted (CHKSUM off).
- MAX_WORDS=4, header 00 05 → err_o=1, byte_ready_o=0, cpu_hold_o=1, no writes; later bytes are never consumed.
- byte_valid_i toggling every other cycle plus an assertion during the WRITE cycle → the byte is held and consumed the next cycle; data written is identical to the back-to-back case.
- Reset pulled low after 6 bytes of a 2-word image → outputs return to reset values at once; a full replay gives the same result as the first test.
- IMEM_LOADER_CHKSUM_EN: 00 01 / 00 00 00 0C / checksum 0D → done_o=1. The same stream with checksum 0E → err_o=1, but the single write (addr 0x0, 0x0000000C) has still occurred.
